// File: rtl/pipelined_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control.
// Stage 1 holds the freshly computed result; stage 2 is the output register
// with zero/parity flags. An accumulator feeds back as operand B on request,
// and a wrapping counter tracks delivered results.
module pipelined_logic_unit #(
    parameter int K = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] inputA,
    input  logic [K-1:0] inputB,
    input  logic [2:0]   opcode,
    input  logic         use_acc,
    input  logic         acc_clr,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [K-1:0] outputC,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         zero,
    output logic         parity,
    output logic [K-1:0] acc,
    output logic [15:0]  result_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Stage-2 payload kept together so it loads/holds as one unit.
    typedef struct packed {
        logic [K-1:0] c;
        logic         z;
        logic         p;
    } out_t;

    function automatic logic [K-1:0] logic_op(input op_e op, input logic [K-1:0] a,
                                              input logic [K-1:0] b);
        logic [K-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    logic         v1_q, v1_d;
    logic [K-1:0] res1_q, res1_d;
    logic         out_valid_q, out_valid_d;
    out_t         out_q, out_d;
    logic [K-1:0] acc_q, acc_d;
    logic [15:0]  cnt_q, cnt_d;

    logic         s2_free;
    logic         accept;
    logic [K-1:0] acc_eff;
    logic [K-1:0] b_eff;
    logic [K-1:0] res_new;

    // Handshake, operand select and next-state for every register.
    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        // Combinational from out_ready so a draining output frees a full pipe.
        in_ready = !rst && (!v1_q || s2_free);
        accept   = in_valid && in_ready;
        // A clear in the same cycle as a use_acc op means "start from zero".
        acc_eff  = acc_clr ? '0 : acc_q;
        b_eff    = use_acc ? acc_eff : inputB;
        res_new  = logic_op(op_e'(opcode), inputA, b_eff);

        v1_d        = v1_q;
        res1_d      = res1_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        // Accumulator takes the new result at accept so chained ops need no bubble.
        if (accept) begin
            res1_d = res_new;
            acc_d  = res_new;
        end else if (acc_clr) begin
            acc_d = '0;
        end

        if (accept)
            v1_d = 1'b1;
        else if (v1_q && s2_free)
            v1_d = 1'b0;

        // Stage 2 only loads when empty or draining, so a stalled result holds.
        if (v1_q && s2_free) begin
            out_valid_d = 1'b1;
            out_d.c     = res1_q;
            out_d.z     = (res1_q == '0);
            out_d.p     = ^res1_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready)
            cnt_d = cnt_q + 16'd1;
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            res1_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            v1_q        <= v1_d;
            res1_q      <= res1_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign outputC      = out_q.c;
    assign zero         = out_q.z;
    assign parity       = out_q.p;
    assign out_valid    = out_valid_q;
    assign acc          = acc_q;
    assign result_count = cnt_q;

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Bench for pipelined_logic_unit: transaction-level model (result queue with
// earliest-presentation edge per item) checked every cycle, plus literal pins.
module tb_pipelined_logic_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inputA = '0, inputB = '0;
    logic [2:0]  opcode = '0;
    logic        use_acc = 1'b0, acc_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, zero, parity;
    logic [15:0] outputC, acc, result_count;

    logic [3:0]  a4 = '0, b4 = '0;
    logic [2:0]  op4 = '0;
    logic        iv4 = 1'b0, or4 = 1'b1;
    logic        ir4, ov4, z4, p4;
    logic [3:0]  c4, acc4;
    logic [15:0] cnt4;

    always #5 clk = ~clk;

    pipelined_logic_unit #(.K(16)) dut (
        .clk(clk), .rst(rst), .inputA(inputA), .inputB(inputB), .opcode(opcode),
        .use_acc(use_acc), .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready),
        .outputC(outputC), .out_valid(out_valid), .out_ready(out_ready), .zero(zero),
        .parity(parity), .acc(acc), .result_count(result_count)
    );

    pipelined_logic_unit #(.K(4)) dut4 (
        .clk(clk), .rst(rst), .inputA(a4), .inputB(b4), .opcode(op4),
        .use_acc(1'b0), .acc_clr(1'b0), .in_valid(iv4), .in_ready(ir4),
        .outputC(c4), .out_valid(ov4), .out_ready(or4), .zero(z4),
        .parity(p4), .acc(acc4), .result_count(cnt4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { logic [15:0] r; int rdy; } item_t;
    typedef struct { logic [15:0] c; logic z; logic p; } cap_t;
    item_t       mq[$];
    cap_t        cap[$];
    bit          cap_en = 1'b0;
    logic [15:0] macc = '0;
    logic [15:0] mcnt = '0;
    int          ecnt = 0;

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Item accepted at edge E is visible after edge E+1, or after the edge that
    // delivered its predecessor, whichever is later. At most two in flight.
    always @(posedge clk) begin
        bit pres, dlv, mrdy;
        logic [15:0] b;
        item_t h;
        ecnt++;
        if (rst) begin
            mq.delete();
            macc = '0;
            mcnt = '0;
        end else begin
            pres = mq.size() > 0 && mq[0].rdy <= ecnt - 1;
            dlv  = pres && out_ready;
            mrdy = mq.size() < 2 || out_ready;
            if (dlv) begin
                void'(mq.pop_front());
                mcnt++;
                if (mq.size() > 0 && mq[0].rdy < ecnt) begin
                    h = mq[0]; h.rdy = ecnt; mq[0] = h;
                end
            end
            if (in_valid && mrdy) begin
                b = use_acc ? (acc_clr ? 16'h0 : macc) : inputB;
                h.r = ref_op(opcode, inputA, b);
                h.rdy = ecnt + 1;
                mq.push_back(h);
                macc = h.r;
            end else if (acc_clr) begin
                macc = '0;
            end
        end
    end

    // Compare against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        bit pres;
        cap_t cc;
        pres = mq.size() > 0 && mq[0].rdy <= ecnt;
        chk("in_ready", in_ready, !rst && (mq.size() < 2 || out_ready));
        chk("out_valid", out_valid, pres);
        if (pres) begin
            chk("outputC", outputC, mq[0].r);
            chk("zero", zero, mq[0].r == 16'h0);
            chk("parity", parity, ^mq[0].r);
        end
        chk("acc", acc, macc);
        chk("result_count", result_count, mcnt);
        if (cap_en && out_valid && out_ready) begin
            cc.c = outputC; cc.z = zero; cc.p = parity;
            cap.push_back(cc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic ua, input logic clr);
        int g;
        bit ok;
        inputA = a; inputB = b; opcode = op; use_acc = ua; acc_clr = clr; in_valid = 1'b1;
        g = 0;
        do begin
            #1; ok = in_ready;
            @(posedge clk); #1;
            g++;
        end while (!ok && g < 50);
        in_valid = 1'b0; use_acc = 1'b0; acc_clr = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic chk_cap(input string nm, input int i, input logic [15:0] c);
        if (cap.size() <= i) begin
            checks++; errors++;
            $display("FAIL %s: got %0d results expected more than %0d", nm, cap.size(), i);
        end else begin
            chk(nm, cap[i].c, c);
        end
    endtask

    logic [15:0] sweep_exp[8] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF,
                                  16'h000F, 16'hF00F, 16'h0F0F, 16'hF0F0};

    initial begin
        int e0, n;
        idle(3);
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst in_ready4", ir4, 1'b0);
        chk("rst outputC", outputC, 16'h0);
        chk("rst zero", zero, 1'b0);
        chk("rst parity", parity, 1'b0);
        chk("rst acc", acc, 16'h0);
        chk("rst count", result_count, 16'h0);
        rst = 1'b0;

        // K=4 width and latency
        a4 = 4'b1111; b4 = 4'b1010; op4 = 3'b001; iv4 = 1'b1; or4 = 1'b1;
        #1 chk("k4 in_ready", ir4, 1'b1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        chk("k4 out_valid N", ov4, 1'b0);
        idle(1);
        chk("k4 out_valid N+1", ov4, 1'b1);
        chk("k4 outputC", c4, 4'b1111);
        chk("k4 zero", z4, 1'b0);
        chk("k4 parity", p4, 1'b0);

        // Opcode sweep at full rate
        out_ready = 1'b1; cap.delete(); cap_en = 1'b1;
        e0 = ecnt;
        for (int i = 0; i < 8; i++) send(16'hF0F0, 16'hFF00, 3'(i), 1'b0, 1'b0);
        chk("sweep cycles", ecnt - e0, 8);
        idle(3);
        for (int i = 0; i < 8; i++) chk_cap("sweep", i, sweep_exp[i]);

        // Accumulator chain, back to back
        cap.delete();
        send(16'h0001, 16'hAAAA, 3'b001, 1'b1, 1'b1);
        send(16'h0003, 16'hAAAA, 3'b010, 1'b1, 1'b0);
        send(16'hFFFF, 16'hAAAA, 3'b000, 1'b1, 1'b0);
        idle(3);
        chk_cap("chain0", 0, 16'h0001);
        chk_cap("chain1", 1, 16'h0002);
        chk_cap("chain2", 2, 16'h0002);
        chk("chain acc", acc, 16'h0002);

        // Flags
        cap.delete();
        send(16'h5555, 16'h5555, 3'b010, 1'b0, 1'b0);
        send(16'h0001, 16'h0000, 3'b111, 1'b0, 1'b0);
        idle(3);
        chk_cap("xor zero val", 0, 16'h0000);
        if (cap.size() == 2) begin
            chk("xor zero flag", cap[0].z, 1'b1);
            chk("xor parity", cap[0].p, 1'b0);
            chk("pass zero flag", cap[1].z, 1'b0);
            chk("pass parity", cap[1].p, 1'b1);
        end else chk("flags count", cap.size(), 2);

        // Back-pressure
        rst = 1'b1; idle(1); rst = 1'b0;
        cap.delete(); out_ready = 1'b0;
        send(16'h0001, 16'h0, 3'b111, 1'b0, 1'b0);
        send(16'h0002, 16'h0, 3'b111, 1'b0, 1'b0);
        inputA = 16'h0003; in_valid = 1'b1;
        #1 chk("bp in_ready", in_ready, 1'b0);
        chk("bp out_valid", out_valid, 1'b1);
        chk("bp outputC", outputC, 16'h0001);
        idle(2);
        chk("bp hold", outputC, 16'h0001);
        out_ready = 1'b1;
        send(16'h0003, 16'h0, 3'b111, 1'b0, 1'b0);
        idle(4);
        chk_cap("bp0", 0, 16'h0001);
        chk_cap("bp1", 1, 16'h0002);
        chk_cap("bp2", 2, 16'h0003);
        chk("bp count", result_count, 16'd3);

        // Mid-operation reset with both stages full
        out_ready = 1'b0;
        send(16'h0007, 16'h0, 3'b111, 1'b0, 1'b0);
        send(16'h0007, 16'h0, 3'b111, 1'b0, 1'b0);
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("mr out_valid", out_valid, 1'b0);
        chk("mr acc", acc, 16'h0);
        chk("mr count", result_count, 16'h0);
        cap.delete(); out_ready = 1'b1;
        idle(4);
        chk("mr stale", cap.size(), 0);

        // Counter wrap
        cap_en = 1'b0;
        inputA = 16'h00AA; opcode = 3'b111; use_acc = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
        n = 0;
        while (result_count != 16'hFFFF && n < 70000) begin @(posedge clk); #1; n++; end
        chk("wrap preload", result_count, 16'hFFFF);
        idle(1);
        chk("wrap", result_count, 16'h0000);
        in_valid = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
